// File: rtl/game_control.sv
// -----------------------------------------------------------------------------
// game_control
//   Top-level game supervisor for the plane / lava / mountains game. It tracks
//   the game state, detects box collisions once per video frame, counts lives,
//   runs the post-hit immunity window and keeps the best score since reset.
//
// Ports
//   clk          system clock
//   resetn       asynchronous, active-low reset
//   start        start request (honoured in IDLE and OVER only)
//   frame_tick   one-clk pulse per video frame
//   plane_y      plane box top row (plane x is the fixed PLANE_X)
//   lava_x/y     lava drop box top-left corner
//   mtn1_x/y     mountain 1 left column / top row (box runs down to SCREEN_B)
//   mtn2_x/y     mountain 2 left column / top row
//   score_in     live score from the obstacle generators
//   game_over    high while IDLE or OVER; freezes the mover blocks
//   state        IDLE=0, PLAY=1, INVULN=2, OVER=3
//   lives        remaining lives
//   hit          one-clk pulse per accepted collision
//   flash        plane blink enable during immunity
//   high_score   best score_in latched on game-over since reset
// -----------------------------------------------------------------------------
module game_control #(
  parameter int PLANE_X       = 60,
  parameter int PLANE_W       = 32,
  parameter int PLANE_H       = 16,
  parameter int LAVA_S        = 8,
  parameter int MTN_W         = 32,
  parameter int SCREEN_B      = 479,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       frame_tick,
  input  logic [9:0] plane_y,
  input  logic [9:0] lava_x,
  input  logic [9:0] lava_y,
  input  logic [9:0] mtn1_x,
  input  logic [9:0] mtn1_y,
  input  logic [9:0] mtn2_x,
  input  logic [9:0] mtn2_y,
  input  logic [6:0] score_in,
  output logic       game_over,
  output logic [1:0] state,
  output logic [1:0] lives,
  output logic       hit,
  output logic       flash,
  output logic [6:0] high_score
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PLAY   = 2'd1;
  localparam logic [1:0] S_INVULN = 2'd2;
  localparam logic [1:0] S_OVER   = 2'd3;

  localparam logic [1:0]  LIVES_LOAD  = 2'(LIVES_INIT);
  localparam logic [7:0]  INVULN_LOAD = 8'(INVULN_FRAMES);

  // All box arithmetic is done in 11 bits so that coordinates near 1023 plus
  // a box size cannot wrap around and alias onto the plane.
  localparam logic [10:0] PLANE_L   = 11'(PLANE_X);
  localparam logic [10:0] PLANE_R   = 11'(PLANE_X + PLANE_W - 1);
  localparam logic [10:0] PLANE_DY  = 11'(PLANE_H - 1);
  localparam logic [10:0] LAVA_D    = 11'(LAVA_S - 1);
  localparam logic [10:0] MTN_D     = 11'(MTN_W - 1);
  localparam logic [10:0] SCREEN_BT = 11'(SCREEN_B);

  logic [7:0]  frame_cnt;
  logic        coll_q;

  logic [10:0] plane_t, plane_b;
  logic        lava_ovl, mtn1_ovl, mtn2_ovl, any_ovl;

  assign plane_t = {1'b0, plane_y};
  assign plane_b = plane_t + PLANE_DY;

  // Inclusive interval intersection on both axes.
  assign lava_ovl = ({1'b0, lava_x} <= PLANE_R) && (PLANE_L <= {1'b0, lava_x} + LAVA_D) &&
                    ({1'b0, lava_y} <= plane_b) && (plane_t <= {1'b0, lava_y} + LAVA_D);

  assign mtn1_ovl = ({1'b0, mtn1_x} <= PLANE_R) && (PLANE_L <= {1'b0, mtn1_x} + MTN_D) &&
                    ({1'b0, mtn1_y} <= plane_b) && (plane_t <= SCREEN_BT);

  assign mtn2_ovl = ({1'b0, mtn2_x} <= PLANE_R) && (PLANE_L <= {1'b0, mtn2_x} + MTN_D) &&
                    ({1'b0, mtn2_y} <= plane_b) && (plane_t <= SCREEN_BT);

  assign any_ovl = lava_ovl || mtn1_ovl || mtn2_ovl;

  // The registered collision flag is the hit pulse itself; it can only be set
  // in PLAY, and the FSM leaves PLAY on the very cycle it is high.
  assign hit       = coll_q;
  assign game_over = (state == S_IDLE) || (state == S_OVER);
  assign flash     = (state == S_INVULN) && frame_cnt[2];

  // NOTE: every register below is assigned with <= so all of them see the
  // pre-edge values of each other; blocking assignments here would make the
  // result depend on statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      lives      <= LIVES_LOAD;
      frame_cnt  <= '0;
      coll_q     <= 1'b0;
      high_score <= '0;
    end else begin
      // Collision sampled only on a frame tick in PLAY. The !coll_q term keeps
      // a tick landing on the hit cycle from producing a second hit.
      coll_q <= (state == S_PLAY) && frame_tick && !coll_q && any_ovl;

      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            state     <= S_PLAY;
            lives     <= LIVES_LOAD;
            frame_cnt <= '0;
          end
        end

        S_PLAY: begin
          if (coll_q) begin
            if (lives <= 2'd1) begin
              lives <= 2'd0;
              state <= S_OVER;
              if (score_in > high_score) high_score <= score_in;
            end else begin
              lives     <= lives - 2'd1;
              state     <= S_INVULN;
              frame_cnt <= INVULN_LOAD;
            end
          end
        end

        S_INVULN: begin
          if (frame_tick) begin
            if (frame_cnt <= 8'd1) begin
              frame_cnt <= '0;
              state     <= S_PLAY;
            end else begin
              frame_cnt <= frame_cnt - 8'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_control.sv
// -----------------------------------------------------------------------------
// tb_game_control
//   Self-checking bench for game_control with default parameters. Inputs are
//   driven on the falling edge and outputs sampled on the falling edge, away
//   from the rising edge the DUT uses. A vector table covers the collision
//   geometry; hand-written sequences cover the multi-cycle game flow.
// -----------------------------------------------------------------------------
module tb_game_control;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       frame_tick;
  logic [9:0] plane_y, lava_x, lava_y, mtn1_x, mtn1_y, mtn2_x, mtn2_y;
  logic [6:0] score_in;
  logic       game_over;
  logic [1:0] state;
  logic [1:0] lives;
  logic       hit;
  logic       flash;
  logic [6:0] high_score;

  int tests_run = 0;
  int tests_failed = 0;

  game_control dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .frame_tick (frame_tick),
    .plane_y    (plane_y),
    .lava_x     (lava_x),
    .lava_y     (lava_y),
    .mtn1_x     (mtn1_x),
    .mtn1_y     (mtn1_y),
    .mtn2_x     (mtn2_x),
    .mtn2_y     (mtn2_y),
    .score_in   (score_in),
    .game_over  (game_over),
    .state      (state),
    .lives      (lives),
    .hit        (hit),
    .flash      (flash),
    .high_score (high_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] py;
    logic [9:0] lx, ly;
    logic [9:0] m1x, m1y;
    logic [9:0] m2x, m2y;
    logic       exp_hit;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic start_game();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One frame tick; returns at the falling edge after the sampling edge,
  // which is where a resulting hit pulse is visible.
  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic park_objects();
    lava_x = 10'd300; lava_y = 10'd200;
    mtn1_x = 10'd250; mtn1_y = 10'd400;
    mtn2_x = 10'd500; mtn2_y = 10'd400;
  endtask

  initial begin
    bit         seen;
    logic [7:0] exp_cnt;

    resetn = 1'b0; start = 1'b0; frame_tick = 1'b0;
    plane_y = 10'd100; score_in = 7'd0;
    park_objects();

    // Geometry table: plane occupies columns 60..91, rows plane_y..plane_y+15.
    //            py     lx     ly     m1x    m1y    m2x    m2y  hit
    vecs[0]  = '{10'd80,  10'd300, 10'd200, 10'd250, 10'd400, 10'd500, 10'd400, 1'b0};
    vecs[1]  = '{10'd100, 10'd70,  10'd110, 10'd250, 10'd400, 10'd500, 10'd400, 1'b1};
    vecs[2]  = '{10'd100, 10'd92,  10'd100, 10'd250, 10'd400, 10'd500, 10'd400, 1'b0};
    vecs[3]  = '{10'd100, 10'd91,  10'd100, 10'd250, 10'd400, 10'd500, 10'd400, 1'b1};
    vecs[4]  = '{10'd100, 10'd53,  10'd100, 10'd250, 10'd400, 10'd500, 10'd400, 1'b1};
    vecs[5]  = '{10'd100, 10'd52,  10'd100, 10'd250, 10'd400, 10'd500, 10'd400, 1'b0};
    vecs[6]  = '{10'd100, 10'd70,  10'd116, 10'd250, 10'd400, 10'd500, 10'd400, 1'b0};
    vecs[7]  = '{10'd100, 10'd70,  10'd115, 10'd250, 10'd400, 10'd500, 10'd400, 1'b1};
    vecs[8]  = '{10'd100, 10'd70,  10'd92,  10'd250, 10'd400, 10'd500, 10'd400, 1'b0};
    vecs[9]  = '{10'd100, 10'd70,  10'd93,  10'd250, 10'd400, 10'd500, 10'd400, 1'b1};
    vecs[10] = '{10'd100, 10'd300, 10'd200, 10'd70,  10'd90,  10'd500, 10'd400, 1'b1};
    vecs[11] = '{10'd100, 10'd300, 10'd200, 10'd1023,10'd0,   10'd500, 10'd400, 1'b0};
    vecs[12] = '{10'd100, 10'd300, 10'd200, 10'd28,  10'd0,   10'd500, 10'd400, 1'b0};
    vecs[13] = '{10'd100, 10'd300, 10'd200, 10'd250, 10'd400, 10'd29,  10'd115, 1'b1};
    vecs[14] = '{10'd100, 10'd300, 10'd200, 10'd250, 10'd400, 10'd29,  10'd116, 1'b0};
    vecs[15] = '{10'd100, 10'd1023,10'd1023,10'd1023,10'd1023,10'd1023,10'd1023,1'b0};

    // Reset state, sampled while reset is held.
    #12;
    check("rst_state", state, 0);
    check("rst_game_over", game_over, 1);
    check("rst_lives", lives, 3);
    check("rst_hit", hit, 0);
    check("rst_flash", flash, 0);
    check("rst_high_score", high_score, 0);

    // Table-driven collision geometry, each vector from a fresh game.
    for (int i = 0; i < NVEC; i++) begin
      do_reset();
      check($sformatf("v%0d_hit_after_release", i), hit, 0);
      plane_y = vecs[i].py;
      lava_x  = vecs[i].lx;  lava_y = vecs[i].ly;
      mtn1_x  = vecs[i].m1x; mtn1_y = vecs[i].m1y;
      mtn2_x  = vecs[i].m2x; mtn2_y = vecs[i].m2y;
      start_game();
      check($sformatf("v%0d_state_play", i), state, 1);
      tick();
      check($sformatf("v%0d_hit", i), hit, int'(vecs[i].exp_hit));
    end

    // Long quiet run: no overlap for 100 frames.
    do_reset();
    plane_y = 10'd80;
    park_objects();
    start_game();
    check("quiet_state", state, 1);
    check("quiet_game_over", game_over, 0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (hit) seen = 1'b1;
    end
    check("quiet_no_hit", int'(seen), 0);
    check("quiet_lives", lives, 3);

    // First hit, immunity window and flash pattern.
    plane_y = 10'd100;
    lava_x = 10'd70; lava_y = 10'd110;
    tick();
    check("hit1_pulse", hit, 1);
    check("hit1_lives_before", lives, 3);
    @(negedge clk);
    check("hit1_pulse_end", hit, 0);
    check("hit1_state", state, 2);
    check("hit1_lives", lives, 2);
    check("hit1_game_over", game_over, 0);
    check("hit1_flash", flash, 1);

    // start must be ignored during immunity.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("invuln_start_ignored", state, 2);
    check("invuln_start_lives", lives, 2);

    exp_cnt = 8'd60;
    seen = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      exp_cnt = exp_cnt - 8'd1;
      if (hit) seen = 1'b1;
      if (exp_cnt != 8'd0) begin
        check($sformatf("invuln_t%0d_state", i), state, 2);
        check($sformatf("invuln_t%0d_flash", i), flash, int'(exp_cnt[2]));
      end
    end
    check("invuln_no_hit", int'(seen), 0);
    check("invuln_end_state", state, 1);
    check("invuln_end_flash", flash, 0);

    tick();
    check("hit2_pulse", hit, 1);
    @(negedge clk);
    check("hit2_lives", lives, 1);
    check("hit2_state", state, 2);

    park_objects();
    for (int i = 0; i < 60; i++) tick();
    check("hit2_back_to_play", state, 1);

    // Double overlap on the final life: one hit, game over, score latched.
    lava_x = 10'd70; lava_y = 10'd110;
    mtn1_x = 10'd70; mtn1_y = 10'd90;
    score_in = 7'd25;
    tick();
    check("final_hit_pulse", hit, 1);
    @(negedge clk);
    check("final_single_hit", hit, 0);
    check("final_lives", lives, 0);
    check("final_state", state, 3);
    check("final_game_over", game_over, 1);
    check("final_high_score", high_score, 25);
    tick();
    check("over_no_hit", hit, 0);
    check("over_lives_floor", lives, 0);

    // Restart from OVER, then reset in the middle of immunity.
    park_objects();
    start_game();
    check("restart_state", state, 1);
    check("restart_lives", lives, 3);
    check("restart_high_score", high_score, 25);
    lava_x = 10'd70; lava_y = 10'd110;
    tick();
    @(negedge clk);
    check("pre_reset_state", state, 2);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_lives", lives, 3);
    check("async_rst_high_score", high_score, 0);
    check("async_rst_game_over", game_over, 1);
    check("async_rst_flash", flash, 0);
    @(negedge clk);
    resetn = 1'b1;

    // A collision registered just before reset must not survive it.
    start_game();
    tick();
    check("pending_hit", hit, 1);
    #1 resetn = 1'b0;
    #1;
    check("pending_hit_killed", hit, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_release_hit", hit, 0);
    check("post_release_state", state, 0);

    // start and frame_tick together in IDLE: only start acts.
    @(negedge clk);
    start = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    start = 1'b0; frame_tick = 1'b0;
    check("coinc_state", state, 1);
    check("coinc_no_hit", hit, 0);
    @(negedge clk);
    check("coinc_no_hit_late", hit, 0);
    check("coinc_lives", lives, 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
